// File: rtl/shift_pkg.sv
// Shared types and widths for the multi-cycle shift controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

    localparam int SHAMT_W = 5;
    localparam int XLEN    = 32;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_RSVD = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Narrow step shifter: moves the accumulator by up to MAX_STEP bits.
// Latency: combinational.
// Backpressure: none; the controller decides when the result is captured.
module shift_step
    import shift_pkg::*;
#(
    parameter int MAX_STEP = 8
) (
    input  logic [XLEN-1:0]                acc,
    input  shift_op_e                      op,
    input  logic [$clog2(MAX_STEP+1)-1:0]  step,
    output logic [XLEN-1:0]                shifted
);

    // One partial shift; SRA replicates the current bit 31 so the sign survives every step
    always_comb begin
        shifted = acc;
        case (op)
            OP_SLL:  shifted = acc << step;
            OP_SRL:  shifted = acc >> step;
            OP_SRA:  shifted = XLEN'($signed(acc) >>> step);
            default: shifted = acc;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA controller sequencing a MAX_STEP-bit step shifter.
// Latency: result valid 1 + ceil(shamt/MAX_STEP) cycles after accept (1 for shamt 0 or reserved op).
// Backpressure: one request in flight; result held in DONE until i_ready, i_flush drops it.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int MAX_STEP = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_op,
    input  logic [XLEN-1:0]   i_operand_a,
    input  logic [XLEN-1:0]   i_operand_b,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_shift_data,
    output logic              o_busy
);

    localparam int STEP_W = $clog2(MAX_STEP + 1);

    if (MAX_STEP != 1 && MAX_STEP != 2 && MAX_STEP != 4 &&
        MAX_STEP != 8 && MAX_STEP != 16 && MAX_STEP != 32) begin : g_bad_max_step
        $error("shift_seq_ctrl: MAX_STEP must be 1, 2, 4, 8, 16 or 32");
    end

    shift_state_e          state;
    shift_op_e             op;
    logic [XLEN-1:0]       acc;
    logic [SHAMT_W-1:0]    rem;
    logic [STEP_W-1:0]     step;
    logic [XLEN-1:0]       acc_shifted;
    logic [SHAMT_W-1:0]    rem_next;
    logic                  unused_operand_b;

    // Only the low five bits of the shift amount are architecturally meaningful
    assign unused_operand_b = ^i_operand_b[XLEN-1:SHAMT_W];

    // New requests are taken only from IDLE, and a flush in the same cycle blocks them
    assign o_ready = (state == S_IDLE) && !i_flush;

    // Step is min(rem, MAX_STEP); rem never underflows because step never exceeds it
    always_comb begin
        step     = (int'(rem) < MAX_STEP) ? STEP_W'(rem) : STEP_W'(MAX_STEP);
        rem_next = rem - SHAMT_W'(step);
    end

    shift_step #(
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .acc     (acc),
        .op      (op),
        .step    (step),
        .shifted (acc_shifted)
    );

    // Control FSM with datapath registers; o_valid rises one cycle after DONE is entered
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= S_IDLE;
            op           <= OP_SLL;
            acc          <= '0;
            rem          <= '0;
            o_valid      <= 1'b0;
            o_shift_data <= '0;
            o_busy       <= 1'b0;
        end else if (i_flush) begin
            state        <= S_IDLE;
            acc          <= '0;
            rem          <= '0;
            o_valid      <= 1'b0;
            o_shift_data <= '0;
            o_busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        acc    <= i_operand_a;
                        op     <= shift_op_e'(i_op);
                        rem    <= i_operand_b[SHAMT_W-1:0];
                        o_busy <= 1'b1;
                        if (i_operand_b[SHAMT_W-1:0] == '0 || shift_op_e'(i_op) == OP_RSVD) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc <= acc_shifted;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!o_valid) begin
                        o_valid      <= 1'b1;
                        o_shift_data <= acc;
                    end else if (i_ready) begin
                        state        <= S_IDLE;
                        acc          <= '0;
                        o_valid      <= 1'b0;
                        o_shift_data <= '0;
                        o_busy       <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    o_valid      <= 1'b0;
                    o_shift_data <= '0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed-vector bench for shift_seq_ctrl with MAX_STEP 1, 8 and 32 instances.
// Latency: n/a.
// Backpressure: exercised via i_ready hold, flush and asynchronous reset sequences.
module tb_shift_seq_ctrl;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_flush;
    logic        i_ready;
    logic [1:0]  i_op;
    logic [31:0] a;
    logic [31:0] b;

    logic        rdy  [3];
    logic        vld  [3];
    logic        busy [3];
    logic [31:0] dat  [3];

    int ms [3] = '{1, 8, 32};
    int n_chk = 0;
    int n_err = 0;

    vec_t vecs [12];

    always #5 clk = ~clk;

    shift_seq_ctrl #(.MAX_STEP(1)) u_s1 (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(rdy[0]),
        .i_op(i_op), .i_operand_a(a), .i_operand_b(b), .i_flush(i_flush),
        .o_valid(vld[0]), .i_ready(i_ready), .o_shift_data(dat[0]), .o_busy(busy[0])
    );

    shift_seq_ctrl #(.MAX_STEP(8)) u_s8 (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(rdy[1]),
        .i_op(i_op), .i_operand_a(a), .i_operand_b(b), .i_flush(i_flush),
        .o_valid(vld[1]), .i_ready(i_ready), .o_shift_data(dat[1]), .o_busy(busy[1])
    );

    shift_seq_ctrl #(.MAX_STEP(32)) u_s32 (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(rdy[2]),
        .i_op(i_op), .i_operand_a(a), .i_operand_b(b), .i_flush(i_flush),
        .o_valid(vld[2]), .i_ready(i_ready), .o_shift_data(dat[2]), .o_busy(busy[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                              input logic [4:0] s);
        case (op)
            2'b00:   return x << s;
            2'b01:   return x >> s;
            2'b10:   return 32'($signed(x) >>> s);
            default: return x;
        endcase
    endfunction

    // Waits (bounded) for o_valid of instance idx; called just after the accept edge.
    task automatic wait_valid(input int idx, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = busy[idx];
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (!busy[idx]) busy_ok = 1'b0;
            if (vld[idx]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic accept(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
        i_op    = op;
        a       = av;
        b       = bv;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic run_vec(input int k);
        int lat;
        bit busy_ok;
        i_op    = vecs[k].op;
        a       = vecs[k].a;
        b       = vecs[k].b;
        i_valid = 1'b1;
        #1;
        chk($sformatf("v%0d_ready", k), 32'(rdy[1]), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_valid(1, lat, busy_ok);
        chk($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
        chk($sformatf("v%0d_busy", k), 32'(busy_ok), 32'd1);
        chk($sformatf("v%0d_data", k), dat[1], vecs[k].exp_data);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        #1;
        chk($sformatf("v%0d_valid_drop", k), 32'(vld[1]), 32'd0);
        chk($sformatf("v%0d_ready_back", k), 32'(rdy[1]), 32'd1);
    endtask

    initial begin
        int  lat;
        bit  bo;
        bit  seen;
        int  lats [3];
        logic [31:0] expd;
        int  expl;

        vecs[0]  = '{2'b10, 32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 5};
        vecs[1]  = '{2'b01, 32'h8000_0000, 32'd4,          32'h0800_0000, 2};
        vecs[2]  = '{2'b10, 32'h8000_0000, 32'd4,          32'hF800_0000, 2};
        vecs[3]  = '{2'b00, 32'h1234_5678, 32'hFFFF_FFE0,  32'h1234_5678, 1};
        vecs[4]  = '{2'b11, 32'h1234_5678, 32'd9,          32'h1234_5678, 1};
        vecs[5]  = '{2'b00, 32'h0000_0001, 32'd31,         32'h8000_0000, 5};
        vecs[6]  = '{2'b00, 32'h1234_5678, 32'd8,          32'h3456_7800, 2};
        vecs[7]  = '{2'b01, 32'hF0F0_F0F0, 32'd9,          32'h0078_7878, 3};
        vecs[8]  = '{2'b10, 32'h7FFF_FFFF, 32'd16,         32'h0000_7FFF, 3};
        vecs[9]  = '{2'b10, 32'h8000_0001, 32'd17,         32'hFFFF_C000, 4};
        vecs[10] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0021,  32'hFFFF_FFFE, 2};
        vecs[11] = '{2'b01, 32'hDEAD_BEEF, 32'd24,         32'h0000_00DE, 4};

        rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(vld[1]), 32'd0);
        chk("rst_data", dat[1], 32'd0);
        chk("rst_busy", 32'(busy[1]), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(rdy[1]), 32'd1);

        // Table-driven vectors on the MAX_STEP=8 instance
        for (int k = 0; k < 12; k++) run_vec(k);

        // Backpressure: result held in DONE, a concurrent request is refused
        accept(2'b00, 32'h0000_0001, 32'd31);
        wait_valid(1, lat, bo);
        chk("bp_latency", 32'(lat), 32'd5);
        i_valid = 1'b1; i_op = 2'b01; a = 32'h0000_FFFF; b = 32'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp_valid_c%0d", c), 32'(vld[1]), 32'd1);
            chk($sformatf("bp_data_c%0d", c), dat[1], 32'h8000_0000);
            chk($sformatf("bp_ready_c%0d", c), 32'(rdy[1]), 32'd0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        #1;
        chk("bp_valid_drop", 32'(vld[1]), 32'd0);
        chk("bp_ready_back", 32'(rdy[1]), 32'd1);
        chk("bp_no_accept", 32'(busy[1]), 32'd0);

        // Flush during the second SHIFT cycle
        accept(2'b10, 32'h8000_0000, 32'd31);
        @(posedge clk); #1;
        i_flush = 1'b1;
        #1;
        chk("fl_ready_blocked", 32'(rdy[1]), 32'd0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        #1;
        chk("fl_ready", 32'(rdy[1]), 32'd1);
        chk("fl_busy", 32'(busy[1]), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (vld[1]) seen = 1'b1;
        end
        chk("fl_no_valid", 32'(seen), 32'd0);

        // Flush together with a request in IDLE: nothing accepted
        i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b00; a = 32'h5; b = 32'd0;
        #1;
        chk("fli_ready", 32'(rdy[1]), 32'd0);
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        #1;
        chk("fli_busy", 32'(busy[1]), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (vld[1]) seen = 1'b1;
        end
        chk("fli_no_valid", 32'(seen), 32'd0);

        // Flush in DONE wins over i_ready
        accept(2'b01, 32'h0000_00F0, 32'd4);
        wait_valid(1, lat, bo);
        chk("fld_latency", 32'(lat), 32'd2);
        i_flush = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0; i_ready = 1'b0;
        #1;
        chk("fld_valid", 32'(vld[1]), 32'd0);
        chk("fld_data", dat[1], 32'd0);
        chk("fld_ready", 32'(rdy[1]), 32'd1);

        // Asynchronous reset between edges while shifting
        accept(2'b10, 32'h8000_0000, 32'd31);
        @(posedge clk); #1;
        chk("ar_busy_before", 32'(busy[1]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy[1]), 32'd0);
        chk("ar_valid", 32'(vld[1]), 32'd0);
        chk("ar_data", dat[1], 32'd0);
        chk("ar_ready", 32'(rdy[1]), 32'd1);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (vld[1]) seen = 1'b1;
        end
        chk("ar_no_valid", 32'(seen), 32'd0);

        // Sweep every op and shamt on all three MAX_STEP instances
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int op = 0; op < 4; op++) begin
            for (int sh = 0; sh < 32; sh++) begin
                i_op    = 2'(op);
                a       = $urandom;
                b       = {27'($urandom), 5'(sh)};
                i_valid = 1'b1;
                @(posedge clk); #1;
                i_valid = 1'b0;
                lats = '{-1, -1, -1};
                for (int c = 1; c <= 40; c++) begin
                    @(posedge clk); #1;
                    for (int i = 0; i < 3; i++)
                        if (lats[i] < 0 && vld[i]) lats[i] = c;
                    if (lats[0] > 0 && lats[1] > 0 && lats[2] > 0) break;
                end
                for (int i = 0; i < 3; i++) begin
                    expd = ref_shift(2'(op), a, 5'(sh));
                    expl = (sh == 0 || op == 3) ? 1 : 1 + (sh + ms[i] - 1) / ms[i];
                    chk($sformatf("sw_m%0d_op%0d_sh%0d_data", ms[i], op, sh), dat[i], expd);
                    chk($sformatf("sw_m%0d_op%0d_sh%0d_lat", ms[i], op, sh), 32'(lats[i]), 32'(expl));
                end
                i_ready = 1'b1;
                @(posedge clk); #1;
                i_ready = 1'b0;
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
